// File: rtl/mult_rtl_pkg.sv
// Shared definitions for the sequential parity-checked multiplier.
//   mult_state_t  - handshake FSM states
//   WIDTH_DEFAULT - default operand width
//   calc_parity   - XOR reduction of a (zero-extended) vector
package mult_rtl_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Callers zero-extend; leading zeros do not change the XOR.
  function automatic logic calc_parity(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Unsigned iterative shift-add multiplier core.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   start       - load operands and begin; ignored sources must keep it low while busy
//   op_a_mag    - unsigned multiplicand (WIDTH bits)
//   op_b_mag    - unsigned multiplier (WIDTH bits)
//   done        - high during the final iteration's cycle; product is valid then
//   product     - 2*WIDTH-bit running sum including the current iteration
// One iteration is performed per clock edge after the loading edge, WIDTH in total.
module mult_shift_add_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a_mag,
  input  logic [WIDTH-1:0]     op_b_mag,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic                busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  acc_next;
  logic                last_iter;

  always_comb begin
    // Multiplicand shifts left and multiplier right, so bit 0 always selects.
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_iter = busy_q && (cnt_q == CntLast);

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a_mag};
      mplier_d = op_b_mag;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (last_iter) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign done    = last_iter;
  assign product = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/mult_seq_parity.sv
// Sequential signed multiplier with parity-checked operands.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   arg_a, arg_b       - two's complement operands
//   arg_a_parity,
//   arg_b_parity       - expected XOR of each operand's bits
//   req                - level request; accepted only in IDLE
//   ack                - one-cycle accept pulse, the cycle after acceptance
//   result             - signed 2*WIDTH product, 0 after a parity error
//   result_parity      - XOR of all result bits
//   result_rdy         - one-cycle result strobe
//   arg_parity_error   - set when an accepted operand had bad parity
// Outputs hold until the next accepted request, which clears only arg_parity_error.
module mult_seq_parity
  import mult_rtl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     arg_a,
  input  logic                 arg_a_parity,
  input  logic [WIDTH-1:0]     arg_b,
  input  logic                 arg_b_parity,
  input  logic                 req,
  output logic                 ack,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_parity,
  output logic                 result_rdy,
  output logic                 arg_parity_error
);

  mult_state_t state_q, state_d;

  logic               ack_q, ack_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               result_parity_q, result_parity_d;
  logic               result_rdy_q, result_rdy_d;
  logic               parity_error_q, parity_error_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;

  logic               a_bad, b_bad;
  logic               accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               core_done;
  logic [2*WIDTH-1:0] core_product;
  logic [2*WIDTH-1:0] signed_product;

  assign a_bad  = calc_parity(64'(arg_a)) != arg_a_parity;
  assign b_bad  = calc_parity(64'(arg_b)) != arg_b_parity;
  assign accept = (state_q == IDLE) && req;

  // Negating -2^(WIDTH-1) yields the same bit pattern, which read unsigned
  // is exactly its magnitude, so no extra bit is needed.
  assign a_mag = arg_a[WIDTH-1] ? (~arg_a + WIDTH'(1)) : arg_a;
  assign b_mag = arg_b[WIDTH-1] ? (~arg_b + WIDTH'(1)) : arg_b;

  // Two's complement negation of zero is zero, so zero products stay zero.
  assign signed_product = (a_neg_q ^ b_neg_q) ? (~core_product + (2*WIDTH)'(1)) : core_product;

  mult_shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .op_a_mag (a_mag),
    .op_b_mag (b_mag),
    .done     (core_done),
    .product  (core_product)
  );

  always_comb begin
    state_d         = state_q;
    ack_d           = 1'b0;
    result_rdy_d    = 1'b0;
    result_d        = result_q;
    result_parity_d = result_parity_q;
    parity_error_d  = parity_error_q;
    a_neg_d         = a_neg_q;
    b_neg_d         = b_neg_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          ack_d          = 1'b1;
          parity_error_d = 1'b0;
          a_neg_d        = arg_a[WIDTH-1];
          b_neg_d        = arg_b[WIDTH-1];
          state_d        = (a_bad || b_bad) ? ERR : CALC;
        end
      end
      CALC: begin
        if (core_done) begin
          result_d        = signed_product;
          result_parity_d = calc_parity(64'(signed_product));
          result_rdy_d    = 1'b1;
          state_d         = DONE;
        end
      end
      ERR: begin
        result_d        = '0;
        result_parity_d = 1'b0;
        parity_error_d  = 1'b1;
        result_rdy_d    = 1'b1;
        state_d         = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ack_q           <= 1'b0;
      result_q        <= '0;
      result_parity_q <= 1'b0;
      result_rdy_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      a_neg_q         <= 1'b0;
      b_neg_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      ack_q           <= ack_d;
      result_q        <= result_d;
      result_parity_q <= result_parity_d;
      result_rdy_q    <= result_rdy_d;
      parity_error_q  <= parity_error_d;
      a_neg_q         <= a_neg_d;
      b_neg_q         <= b_neg_d;
    end
  end

  assign ack              = ack_q;
  assign result           = result_q;
  assign result_parity    = result_parity_q;
  assign result_rdy       = result_rdy_q;
  assign arg_parity_error = parity_error_q;

endmodule
